// File: rtl/fifo_pkg.sv
// Shared helpers for the programmable FIFO: width functions and the error-flag record.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_mem[i_waddr] <= r_mem[i_waddr];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with occupancy count, programmable thresholds and sticky errors.
// Define FIFO_PROG_FWFT_EN for first-word-fall-through; default is registered read, latency 1.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_w_en,
  input  logic [DATA_WIDTH-1:0]         i_data_in,
  input  logic                          i_r_en,
  input  logic                          i_flush,
  input  logic                          i_clr_err,
  output logic [DATA_WIDTH-1:0]         o_data_out,
  output logic                          o_rd_valid,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam int CNT_W  = cnt_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_prog: DEPTH must be a power of 2 and at least 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("fifo_prog: AFULL_TH must lie in 1..DEPTH");
  end
  if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
    $error("fifo_prog: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  err_flags_t            r_err;

  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  err_flags_t            w_err_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_rej;
  logic                  w_rd_rej;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Same index with opposite wrap bits means the write pointer is a full lap ahead.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_wr_acc = i_w_en & ~w_full  & ~i_flush;
  assign w_rd_acc = i_r_en & ~w_empty & ~i_flush;
  assign w_wr_rej = i_w_en &  w_full  & ~i_flush;
  assign w_rd_rej = i_r_en &  w_empty & ~i_flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (i_data_in),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (i_flush) begin
      w_wr_ptr_nxt = {PTR_W{1'b0}};
      w_rd_ptr_nxt = {PTR_W{1'b0}};
      w_count_nxt  = {CNT_W{1'b0}};
    end else begin
      if (w_wr_acc) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_rd_acc) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // A new error event beats a simultaneous clear.
  always_comb begin
    w_err_nxt           = r_err;
    w_err_nxt.overflow  = w_wr_rej | (r_err.overflow  & ~i_clr_err);
    w_err_nxt.underflow = w_rd_rej | (r_err.underflow & ~i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_err    <= '{overflow: 1'b0, underflow: 1'b0};
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_err    <= w_err_nxt;
    end
  end

`ifdef FIFO_PROG_FWFT_EN
  assign o_data_out = w_empty ? {DATA_WIDTH{1'b0}} : w_mem_rdata;
  assign o_rd_valid = ~w_empty;
`else
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= {DATA_WIDTH{1'b0}};
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= w_mem_rdata;
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_rd_valid = r_rd_valid;
`endif

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= CNT_W'(AFULL_TH));
  assign o_almost_empty = (r_count <= CNT_W'(AEMPTY_TH));
  assign o_count        = r_count;
  assign o_overflow     = r_err.overflow;
  assign o_underflow    = r_err.underflow;

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: directed scenarios plus random traffic against a queue-based model.
// Honours FIFO_PROG_FWFT_EN the same way the design does.
module tb_fifo_prog;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AFULL_TH = 6;
  localparam int AEMPTY_TH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic [DW-1:0] data_in = 8'h00;
  logic          r_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_do = 8'h00;
  logic          m_rv = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_prog #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (AFULL_TH),
    .AEMPTY_TH  (AEMPTY_TH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_w_en         (w_en),
    .i_data_in      (data_in),
    .i_r_en         (r_en),
    .i_flush        (flush),
    .i_clr_err      (clr_err),
    .o_data_out     (data_out),
    .o_rd_valid     (rd_valid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_do  = 8'h00;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic fl, input logic ce);
    int  sz;
    bit  is_full, is_empty;
    sz       = q.size();
    is_full  = (sz == DEPTH);
    is_empty = (sz == 0);
    if (fl) begin
      q.delete();
      m_rv  = 1'b0;
      m_ovf = m_ovf & ~ce;
      m_udf = m_udf & ~ce;
    end else begin
      m_ovf = (w && is_full)  | (m_ovf & ~ce);
      m_udf = (r && is_empty) | (m_udf & ~ce);
      m_rv  = 1'b0;
      if (r && !is_empty) begin
        m_do = q.pop_front();
        m_rv = 1'b1;
      end
      if (w && !is_full) q.push_back(d);
    end
  endtask

  task automatic check_all(input string ctx);
    int            sz;
    logic [DW-1:0] exp_do;
    logic          exp_rv;
    sz = q.size();
`ifdef FIFO_PROG_FWFT_EN
    exp_do = (sz != 0) ? q[0] : 8'h00;
    exp_rv = (sz != 0);
`else
    exp_do = m_do;
    exp_rv = m_rv;
`endif
    check_eq({ctx, ".count"},        32'(count),        32'(sz));
    check_eq({ctx, ".full"},         32'(full),         32'(sz == DEPTH));
    check_eq({ctx, ".empty"},        32'(empty),        32'(sz == 0));
    check_eq({ctx, ".almost_full"},  32'(almost_full),  32'(sz >= AFULL_TH));
    check_eq({ctx, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEMPTY_TH));
    check_eq({ctx, ".overflow"},     32'(overflow),     32'(m_ovf));
    check_eq({ctx, ".underflow"},    32'(underflow),    32'(m_udf));
    check_eq({ctx, ".rd_valid"},     32'(rd_valid),     32'(exp_rv));
    check_eq({ctx, ".data_out"},     32'(data_out),     32'(exp_do));
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input string ctx, input logic w, input logic [DW-1:0] d, input logic r,
                      input logic fl, input logic ce);
    w_en = w; data_in = d; r_en = r; flush = fl; clr_err = ce;
    @(posedge clk);
    model_edge(w, d, r, fl, ce);
    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= DEPTH; i++) begin
      step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 5) check_eq("afull_before_6th", 32'(almost_full), 32'(0));
      if (i == 6) check_eq("afull_at_6th", 32'(almost_full), 32'(1));
    end
    check_eq("full_after_8", 32'(full), 32'(1));
    for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("empty_after_drain", 32'(empty), 32'(1));

    for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step("rw_full", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check_eq("rw_full_count", 32'(count), 32'(7));
    check_eq("rw_full_ovf", 32'(overflow), 32'(1));
`ifndef FIFO_PROG_FWFT_EN
    check_eq("rw_full_data", 32'(data_out), 32'(8'h01));
`endif
    step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_cleared", 32'(overflow), 32'(0));
    for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    step("rw_empty", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check_eq("rw_empty_udf", 32'(underflow), 32'(1));
    step("read_55", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
`ifndef FIFO_PROG_FWFT_EN
    check_eq("read_55_data", 32'(data_out), 32'(8'h55));
`endif

    for (int i = 0; i < 4; i++) step("prime", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_count", 32'(count), 32'(4));
    end
    for (int i = 0; i < 5; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step("flush_wr", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    check_eq("flush_count", 32'(count), 32'(0));
    check_eq("flush_ovf", 32'(overflow), 32'(0));

`ifdef FIFO_PROG_FWFT_EN
    step("fwft_3c", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("fwft_data", 32'(data_out), 32'(8'h3C));
    check_eq("fwft_valid", 32'(rd_valid), 32'(1));
    step("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      step("rand",
           ($urandom_range(0, 99) < wp),
           8'($urandom),
           ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 15) == 0));
    end

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    step("pre_rst_rd", 1'b1, 8'hD9, 1'b1, 1'b0, 1'b0);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hDD;
    #2;
    rst = 1'b1;
    w_en = 1'b0; r_en = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all("post_rst");
    step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
